sha3_256_sponge: RTL
====================

Name: sha3_256_sponge

Overview:
- Absorb and pad front-end for SHA3-256, sitting directly upstream of keccakf_core.
- Accepts a byte-ordered message as 64-bit words and packs them into 136-byte (17-lane) rate blocks.
- Applies FIPS-202 padding, XORs each block into the running 1600-bit state, and sequences keccakf_core through one permutation per block.
- Presents the 256-bit digest when the final permutation completes.

Parameters:
- RATE_LANES, 17, 64-bit lanes per rate block (136 bytes for SHA3-256).
- DIGEST_W, 256, digest width in bits (lanes 0..3 of the state).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  message word valid
- o_ready  out  1  word accepted when i_valid & o_ready
- i_data  in  64  message word; first stream byte in [63:56]
- i_last  in  1  final word of message
- i_bytes  in  4  valid bytes in word, MSB-aligned; 8 unless i_last; 0..8 legal with i_last (0 = empty tail)
- o_kf_start  out  1  one-cycle start pulse to keccakf_core
- o_kf_vin  out  1600  permutation input; lane k at [1599-64k -: 64]
- i_kf_vout  in  1600  permutation output
- i_kf_done  in  1  permutation complete
- o_digest  out  256  digest; first digest byte in [255:248]
- o_digest_valid  out  1  digest valid

Behaviour:
- Reset values: o_ready=0, o_kf_start=0, o_kf_vin=0, o_digest=0, o_digest_valid=0. State register, block buffer and lane counter are cleared; FSM goes to IDLE.
- States: IDLE, ABSORB, PAD, PERM, WAIT, DONE.
- IDLE: o_ready=1 and the state is zero. First accepted word → ABSORB; that word is stored as lane 0.
- ABSORB: o_ready=1; one word accepted per cycle into buffer lane cnt (5-bit, 0..16).
  - Non-last word at cnt=16 → PERM with a full block, no padding.
  - i_last word: record the byte position p = 8*cnt + i_bytes → PAD.
- PAD (one cycle, o_ready=0):
  - Zero buffer bytes from p onward.
  - XOR 0x06 into byte p.
  - XOR 0x80 into byte 135 (lane 16 bits [7:0]).
  - p=135 gives 0x86.
  - If the last word exactly fills byte 135 (p=136), the current block permutes unpadded and a further all-pad block (byte0=0x06, byte135=0x80) is absorbed before DONE; a pad_pending flag tracks this.
  - Then → PERM.
- PERM: o_kf_vin <= state ^ {buffer, 512'b0}; o_kf_start=1 for exactly one cycle; → WAIT. The buffer is then cleared and cnt=0.
- WAIT: o_ready=0. When i_kf_done is seen, state <= i_kf_vout and:
  - If the message is padded and finished → DONE.
  - If pad_pending → PAD with p=0.
  - Otherwise → ABSORB.
  - i_kf_done outside WAIT is ignored.
- DONE: o_digest <= state[1599:1344]; o_digest_valid=1 and held. State and cnt are cleared. → IDLE.
  - o_digest_valid drops on the cycle the next message's first word is accepted; o_digest holds its value until the next DONE.
- Back-pressure: words are held by the producer while o_ready=0; no data is lost or duplicated.
- Latency, single-block message: the last word is accepted at cycle t; PAD at t+1; o_kf_start at t+2; o_digest_valid rises 2 cycles after i_kf_done.
- Asserting i_rst_n low at any point, including mid-permutation, aborts the hash immediately and returns all outputs to reset values.
- A late i_kf_done from the aborted permutation arrives in IDLE and is ignored.

Optional Feature:
- SHA3_KECCAK_PAD_EN
  - Defined: the domain byte is 0x01 instead of 0x06 (legacy Keccak-256). Coincident with the final byte it becomes 0x81.
  - Undefined: FIPS-202 SHA3-256 padding (0x06).

Test Plan:
- Empty message (single word, i_last=1, i_bytes=0) → o_kf_vin lane0=0x0600000000000000, lane16=0x0000000000000080, all other lanes 0; after done, o_digest=a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a.
- "abc" (i_data=0x6162630000000000, i_bytes=3, i_last) → lane0=0x6162630600000000; o_digest=3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
- 200 bytes of 0xa3 (25 words, last i_bytes=8) → two permutations. Second block = lanes 0..7 0xa3.., lane8=0x0600000000000000, lane16=..80, XORed with the first result. o_digest=79f38adec5c20307a98ef76e8324afbfd46cfd81b22e3973c65fa1bd9de31787.
- 136 bytes of 0x00 (17 full words, last at cnt=16) → two o_kf_start pulses; the second block contains only 0x06 at byte 0 and 0x80 at byte 135.
- 135 bytes (last word i_bytes=7 at cnt=16) → lane16 byte 7 = 0x86; a single permutation.
- Random i_valid gaps and a held-off i_kf_done (≥100 cycles) → o_ready=0 throughout WAIT and the digest is unchanged. Pulsing i_rst_n low during WAIT → all outputs 0; a following empty-message hash still yields a7ffc6f8...434a.

Source files
------------

// File: rtl/sha3_256_sponge.sv
// SHA3-256 absorb/pad front-end for an external keccakf_core.
// Packs 64-bit message words into rate blocks, applies padding, XORs each
// block into the running state and sequences one permutation per block.
// Optional build macro SHA3_KECCAK_PAD_EN: use legacy Keccak domain byte 0x01
// instead of the FIPS-202 SHA3 domain byte 0x06.
module sha3_256_sponge #(
    parameter int RATE_LANES = 17,
    parameter int DIGEST_W   = 256
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [63:0]     i_data,
    input  logic            i_last,
    input  logic [3:0]      i_bytes,
    output logic            o_kf_start,
    output logic [1599:0]   o_kf_vin,
    input  logic [1599:0]   i_kf_vout,
    input  logic            i_kf_done,
    output logic [DIGEST_W-1:0] o_digest,
    output logic            o_digest_valid
);

`ifdef SHA3_KECCAK_PAD_EN
    localparam logic [7:0] DOMAIN_BYTE = 8'h01;
`else
    localparam logic [7:0] DOMAIN_BYTE = 8'h06;
`endif

    localparam int RATE_BYTES = 8 * RATE_LANES;
    localparam int BUF_W      = 64 * RATE_LANES;
    localparam int CAP_W      = 1600 - BUF_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ABSORB = 3'd1;
    localparam logic [2:0] S_PAD    = 3'd2;
    localparam logic [2:0] S_PERM   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]          fsm_q, fsm_d;
    logic [1599:0]       state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [8:0]          pos_q, pos_d;
    logic                fin_q, fin_d;
    logic                pad_pend_q, pad_pend_d;
    logic                ready_q, ready_d;
    logic                kf_start_q, kf_start_d;
    logic [1599:0]       kf_vin_q, kf_vin_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic                digest_valid_q, digest_valid_d;
    logic                accept;

    assign accept         = i_valid & ready_q;
    assign o_ready        = ready_q;
    assign o_kf_start     = kf_start_q;
    assign o_kf_vin       = kf_vin_q;
    assign o_digest       = digest_q;
    assign o_digest_valid = digest_valid_q;

    // Next-state logic: absorb words, pad the tail, launch and collect permutations.
    always_comb begin
        fsm_d          = fsm_q;
        state_d        = state_q;
        buf_d          = buf_q;
        cnt_d          = cnt_q;
        pos_d          = pos_q;
        fin_d          = fin_q;
        pad_pend_d     = pad_pend_q;
        kf_start_d     = 1'b0;
        kf_vin_d       = kf_vin_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;

        case (fsm_q)
            S_IDLE, S_ABSORB: begin
                if (accept) begin
                    buf_d[BUF_W-1-64*int'(cnt_q) -: 64] = i_data;
                    digest_valid_d = 1'b0;
                    if (i_last) begin
                        pos_d = 9'({cnt_q, 3'b000}) + 9'(i_bytes);
                        fsm_d = S_PAD;
                    end else if (int'(cnt_q) == RATE_LANES - 1) begin
                        fsm_d = S_PERM;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                        fsm_d = S_ABSORB;
                    end
                end
            end
            S_PAD: begin
                // A tail that exactly fills the block leaves padding for an extra block.
                if (int'(pos_q) >= RATE_BYTES) begin
                    pad_pend_d = 1'b1;
                end else begin
                    for (int b = 0; b < RATE_BYTES; b++) begin
                        if (b >= int'(pos_q)) begin
                            buf_d[BUF_W-1-8*b -: 8] = 8'h00;
                        end
                    end
                    buf_d[BUF_W-1-8*int'(pos_q) -: 8] = DOMAIN_BYTE;
                    buf_d[7:0] = buf_d[7:0] ^ 8'h80;
                    fin_d = 1'b1;
                end
                fsm_d = S_PERM;
            end
            S_PERM: begin
                buf_d = '0;
                cnt_d = 5'd0;
                fsm_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_kf_done) begin
                    state_d = i_kf_vout;
                    if (fin_q) begin
                        fin_d = 1'b0;
                        fsm_d = S_DONE;
                    end else if (pad_pend_q) begin
                        pad_pend_d = 1'b0;
                        pos_d      = 9'd0;
                        fsm_d      = S_PAD;
                    end else begin
                        fsm_d = S_ABSORB;
                    end
                end
            end
            S_DONE: begin
                digest_d       = state_q[1599 -: DIGEST_W];
                digest_valid_d = 1'b1;
                state_d        = '0;
                cnt_d          = 5'd0;
                fsm_d          = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase

        // Launch the permutation together with its input as PERM is entered,
        // so the start pulse coincides with the PERM cycle.
        if (fsm_d == S_PERM && fsm_q != S_PERM) begin
            kf_start_d = 1'b1;
            kf_vin_d   = state_q ^ {buf_d, {CAP_W{1'b0}}};
        end

        ready_d = (fsm_d == S_IDLE) || (fsm_d == S_ABSORB);
    end

    // State registers; reset aborts any hash in flight and clears all outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q          <= S_IDLE;
            state_q        <= '0;
            buf_q          <= '0;
            cnt_q          <= 5'd0;
            pos_q          <= 9'd0;
            fin_q          <= 1'b0;
            pad_pend_q     <= 1'b0;
            ready_q        <= 1'b0;
            kf_start_q     <= 1'b0;
            kf_vin_q       <= '0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            fsm_q          <= fsm_d;
            state_q        <= state_d;
            buf_q          <= buf_d;
            cnt_q          <= cnt_d;
            pos_q          <= pos_d;
            fin_q          <= fin_d;
            pad_pend_q     <= pad_pend_d;
            ready_q        <= ready_d;
            kf_start_q     <= kf_start_d;
            kf_vin_q       <= kf_vin_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
        end
    end

endmodule
